// File: rtl/exp8_pkg.sv
// Shared definitions for the Exp8 burst arbiter and its capture helper.
package exp8_pkg;

    localparam int SYM_W     = 2;
    localparam int BURST_MAX = 8;
    localparam int LEN_W     = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_DRIVE = 2'd1,
        ARB_DRAIN = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    // State codes of the shared Exp8 sequence FSM, used by bench models.
    typedef enum logic [2:0] {
        EXP8_A = 3'd0,
        EXP8_B = 3'd1,
        EXP8_C = 3'd2,
        EXP8_D = 3'd3,
        EXP8_E = 3'd4,
        EXP8_F = 3'd5,
        EXP8_G = 3'd6,
        EXP8_H = 3'd7
    } exp8_state_t;

    // Oversized burst lengths are treated as a full burst.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len, input int max_len);
        return (len > LEN_W'(max_len)) ? LEN_W'(max_len) : len;
    endfunction

endpackage

// File: rtl/exp8_burst_capture.sv
// Collects the {y,z} answers of the shared FSM for one burst. Every issued
// symbol is tracked through an LAT-deep valid pipeline so the answer is
// stored in the slot of the symbol that produced it, independent of how far
// the drive side has advanced.
module exp8_burst_capture
    import exp8_pkg::*;
#(
    parameter int BURST_MAX = exp8_pkg::BURST_MAX,
    parameter int LAT       = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     issue_i,
    input  logic [LEN_W-1:0]         len_i,
    input  logic                     y_i,
    input  logic                     z_i,
    output logic [2*BURST_MAX-1:0]   data_o,
    output logic                     last_o
);

    logic [LAT-1:0]          vld_q, vld_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic [2*BURST_MAX-1:0]  data_q, data_d;
    logic                    cap_en;

    assign cap_en = vld_q[LAT-1];
    assign data_o = data_q;
    assign last_o = cap_en && ((cnt_q + LEN_W'(1)) == len_i);

    // Advance the alignment pipeline and store the answer in its symbol slot.
    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = issue_i;
        cnt_d    = cnt_q;
        data_d   = data_q;
        if (cap_en) begin
            for (int i = 0; i < BURST_MAX; i++) begin
                if (cnt_q == LEN_W'(i)) begin
                    data_d[SYM_W*i +: SYM_W] = {y_i, z_i};
                end
            end
            cnt_d = cnt_q + LEN_W'(1);
        end
        if (start_i) begin
            vld_d  = '0;
            cnt_d  = '0;
            data_d = '0;
        end
    end

    // Capture state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/exp8_arbiter.sv
// Two-requester front end for a shared Exp8 sequence FSM. One burst at a
// time is granted (round robin on contention), its symbols are driven on
// w/x one per cycle, and the collected {y,z} answers return to the owner
// as a single-cycle response.
module exp8_arbiter
    import exp8_pkg::*;
#(
    parameter int BURST_MAX = exp8_pkg::BURST_MAX,
    parameter int LAT       = 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [2*BURST_MAX-1:0]   req0_syms,
    input  logic [LEN_W-1:0]         req0_len,
    output logic                     rsp0_valid,
    output logic [2*BURST_MAX-1:0]   rsp0_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [2*BURST_MAX-1:0]   req1_syms,
    input  logic [LEN_W-1:0]         req1_len,
    output logic                     rsp1_valid,
    output logic [2*BURST_MAX-1:0]   rsp1_data,
    output logic                     w,
    output logic                     x,
    input  logic                     y,
    input  logic                     z
);

    arb_state_t              state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    ptr_q, ptr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [2*BURST_MAX-1:0]  syms_q, syms_d;
    logic [LEN_W-1:0]        drv_cnt_q, drv_cnt_d;
    logic                    w_q, w_d, x_q, x_d;
    logic                    issue_q, issue_d;
    logic [2*BURST_MAX-1:0]  rsp0_hold_q, rsp0_hold_d;
    logic [2*BURST_MAX-1:0]  rsp1_hold_q, rsp1_hold_d;
    logic                    grant0, grant1, start;
    logic [2*BURST_MAX-1:0]  sel_syms;
    logic [LEN_W-1:0]        sel_len;
    logic [2*BURST_MAX-1:0]  cap_data;
    logic                    cap_last;

    // The pointer only matters when both requesters compete.
    assign grant0 = (state_q == ARB_IDLE) && !Rst && req0_valid && (!req1_valid || !ptr_q);
    assign grant1 = (state_q == ARB_IDLE) && !Rst && req1_valid && (!req0_valid ||  ptr_q);

    assign sel_syms   = grant1 ? req1_syms : req0_syms;
    assign sel_len    = clamp_len(grant1 ? req1_len : req0_len, BURST_MAX);
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign w          = w_q;
    assign x          = x_q;

    assign rsp0_valid = (state_q == ARB_RESP) && !owner_q && !Rst;
    assign rsp1_valid = (state_q == ARB_RESP) &&  owner_q && !Rst;
    assign rsp0_data  = rsp0_valid ? cap_data : rsp0_hold_q;
    assign rsp1_data  = rsp1_valid ? cap_data : rsp1_hold_q;

    exp8_burst_capture #(
        .BURST_MAX (BURST_MAX),
        .LAT       (LAT)
    ) u_capture (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .start_i (start),
        .issue_i (issue_q),
        .len_i   (len_q),
        .y_i     (y),
        .z_i     (z),
        .data_o  (cap_data),
        .last_o  (cap_last)
    );

    // Arbitration, symbol issue and response sequencing.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        syms_d      = syms_q;
        drv_cnt_d   = drv_cnt_q;
        w_d         = 1'b0;
        x_d         = 1'b0;
        issue_d     = 1'b0;
        rsp0_hold_d = rsp0_hold_q;
        rsp1_hold_d = rsp1_hold_q;
        start       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grant0 || grant1) begin
                    start   = 1'b1;
                    owner_d = grant1;
                    ptr_d   = grant0;
                    len_d   = sel_len;
                    if (sel_len == '0) begin
                        state_d = ARB_RESP;
                    end else begin
                        {w_d, x_d} = sel_syms[SYM_W-1:0];
                        issue_d    = 1'b1;
                        syms_d     = sel_syms >> SYM_W;
                        drv_cnt_d  = LEN_W'(1);
                        state_d    = ARB_DRIVE;
                    end
                end
            end
            ARB_DRIVE: begin
                if (drv_cnt_q < len_q) begin
                    {w_d, x_d} = syms_q[SYM_W-1:0];
                    issue_d    = 1'b1;
                    syms_d     = syms_q >> SYM_W;
                    drv_cnt_d  = drv_cnt_q + LEN_W'(1);
                end else begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (cap_last) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
                if (owner_q) begin
                    rsp1_hold_d = cap_data;
                end else begin
                    rsp0_hold_d = cap_data;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers; reset abandons any burst in flight.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= 1'b0;
            ptr_q       <= 1'b0;
            len_q       <= '0;
            syms_q      <= '0;
            drv_cnt_q   <= '0;
            w_q         <= 1'b0;
            x_q         <= 1'b0;
            issue_q     <= 1'b0;
            rsp0_hold_q <= '0;
            rsp1_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            syms_q      <= syms_d;
            drv_cnt_q   <= drv_cnt_d;
            w_q         <= w_d;
            x_q         <= x_d;
            issue_q     <= issue_d;
            rsp0_hold_q <= rsp0_hold_d;
            rsp1_hold_q <= rsp1_hold_d;
        end
    end

endmodule

// File: tb/tb_exp8_arbiter.sv
// Directed bench for exp8_arbiter: one instance with a one-cycle FSM stub
// (LAT=1) and one with a three-cycle stub (LAT=3).
module tb_exp8_arbiter;

    logic        Clk, Rst;
    logic        req0_valid, req0_ready, rsp0_valid;
    logic [15:0] req0_syms, rsp0_data;
    logic [3:0]  req0_len;
    logic        req1_valid, req1_ready, rsp1_valid;
    logic [15:0] req1_syms, rsp1_data;
    logic [3:0]  req1_len;
    logic        w, x, y, z;

    logic        b_req0_valid, b_req0_ready, b_rsp0_valid;
    logic [15:0] b_req0_syms, b_rsp0_data;
    logic [3:0]  b_req0_len;
    logic        b_req1_valid, b_req1_ready, b_rsp1_valid;
    logic [15:0] b_req1_syms, b_rsp1_data;
    logic [3:0]  b_req1_len;
    logic        b_w, b_x, b_y, b_z;
    logic [1:0]  d1, d2;

    logic [5:0]  st, b_st;
    int          nvec = 0;
    int          nerr = 0;

    assign st   = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, w, x};
    assign b_st = {b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_w, b_x};

    exp8_arbiter #(.BURST_MAX(8), .LAT(1)) dut (
        .Clk(Clk), .Rst(Rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_syms(req0_syms), .req0_len(req0_len),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_syms(req1_syms), .req1_len(req1_len),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .w(w), .x(x), .y(y), .z(z)
    );

    exp8_arbiter #(.BURST_MAX(8), .LAT(3)) dut3 (
        .Clk(Clk), .Rst(Rst),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_syms(b_req0_syms), .req0_len(b_req0_len),
        .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_syms(b_req1_syms), .req1_len(b_req1_len),
        .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data),
        .w(b_w), .x(b_x), .y(b_y), .z(b_z)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Echo stubs standing in for the shared FSM: one and three cycles of delay.
    always @(posedge Clk) begin
        y <= w;
        z <= x;
        d1 <= {b_w, b_x};
        d2 <= d1;
        {b_y, b_z} <= d2;
    end

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        req0_valid = 1'b0; req0_syms = '0; req0_len = '0;
        req1_valid = 1'b0; req1_syms = '0; req1_len = '0;
        b_req0_valid = 1'b0; b_req0_syms = '0; b_req0_len = '0;
        b_req1_valid = 1'b0; b_req1_syms = '0; b_req1_len = '0;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_len = 4'd1; req1_len = 4'd1;
        #1;
        nvec++;
        if (st !== 6'b000000) begin nerr++; $display("FAIL reset_ready_gated: got %b want %b", st, 6'b000000); end
        @(negedge Clk);
        nvec++;
        if ({st, rsp0_data, rsp1_data, b_st} !== 44'd0) begin
            nerr++; $display("FAIL reset_outputs: got %b %h %h %b want all zero", st, rsp0_data, rsp1_data, b_st);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        Rst = 1'b0;
    endtask

    task automatic test_single_burst();
        logic [5:0]  expSt [8]   = '{6'b100000, 6'b000000, 6'b000001, 6'b000010,
                                     6'b000011, 6'b000000, 6'b001000, 6'b000000};
        logic [15:0] expData [8] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h00E4, 16'h00E4};
        do_reset();
        req0_valid = 1'b1; req0_syms = 16'h00E4; req0_len = 4'd4;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) #1; else @(negedge Clk);
            nvec++;
            if (st !== expSt[c]) begin nerr++; $display("FAIL single_status c=%0d: got %b want %b", c, st, expSt[c]); end
            nvec++;
            if (rsp0_data !== expData[c]) begin nerr++; $display("FAIL single_data c=%0d: got %h want %h", c, rsp0_data, expData[c]); end
            if (c == 0) begin @(posedge Clk); #1; req0_valid = 1'b0; end
        end
    endtask

    task automatic test_simultaneous();
        logic [5:0]  expSt [9] = '{6'b100000, 6'b000011, 6'b000000, 6'b001000, 6'b010000,
                                   6'b000010, 6'b000000, 6'b000100, 6'b000000};
        logic [31:0] expData [9] = '{32'h0, 32'h0, 32'h0, {16'h3, 16'h0}, {16'h3, 16'h0},
                                     {16'h3, 16'h0}, {16'h3, 16'h0}, {16'h3, 16'h2}, {16'h3, 16'h2}};
        do_reset();
        req0_valid = 1'b1; req0_syms = 16'h0003; req0_len = 4'd1;
        req1_valid = 1'b1; req1_syms = 16'h0002; req1_len = 4'd1;
        for (int c = 0; c < 9; c++) begin
            if (c == 0) #1; else @(negedge Clk);
            nvec++;
            if (st !== expSt[c]) begin nerr++; $display("FAIL simul_status c=%0d: got %b want %b", c, st, expSt[c]); end
            nvec++;
            if ({rsp0_data, rsp1_data} !== expData[c]) begin
                nerr++; $display("FAIL simul_data c=%0d: got %h want %h", c, {rsp0_data, rsp1_data}, expData[c]);
            end
            if (expSt[c][5]) begin @(posedge Clk); #1; req0_valid = 1'b0; end
            if (expSt[c][4]) begin @(posedge Clk); #1; req1_valid = 1'b0; end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  expSt;
        logic [31:0] expData;
        int          ph, own;
        do_reset();
        req0_valid = 1'b1; req0_syms = 16'h0001; req0_len = 4'd1;
        req1_valid = 1'b1; req1_syms = 16'h0002; req1_len = 4'd1;
        for (int c = 0; c < 16; c++) begin
            if (c == 0) #1; else @(negedge Clk);
            ph  = c % 4;
            own = (c / 4) % 2;
            case (ph)
                0:       expSt = (own == 0) ? 6'b100000 : 6'b010000;
                1:       expSt = (own == 0) ? 6'b000001 : 6'b000010;
                3:       expSt = (own == 0) ? 6'b001000 : 6'b000100;
                default: expSt = 6'b000000;
            endcase
            expData = {((c >= 3) ? 16'h0001 : 16'h0000), ((c >= 7) ? 16'h0002 : 16'h0000)};
            nvec++;
            if (st !== expSt) begin nerr++; $display("FAIL b2b_status c=%0d: got %b want %b", c, st, expSt); end
            nvec++;
            if ({rsp0_data, rsp1_data} !== expData) begin
                nerr++; $display("FAIL b2b_data c=%0d: got %h want %h", c, {rsp0_data, rsp1_data}, expData);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_len_zero();
        logic [5:0]  expSt [7]   = '{6'b010000, 6'b000011, 6'b000000, 6'b000100,
                                     6'b010000, 6'b000100, 6'b000000};
        logic [15:0] expData [7] = '{16'h0, 16'h0, 16'h0, 16'h3, 16'h3, 16'h0, 16'h0};
        do_reset();
        req1_valid = 1'b1; req1_syms = 16'h0003; req1_len = 4'd1;
        for (int c = 0; c < 7; c++) begin
            if (c == 0) #1; else @(negedge Clk);
            nvec++;
            if (st !== expSt[c]) begin nerr++; $display("FAIL len0_status c=%0d: got %b want %b", c, st, expSt[c]); end
            nvec++;
            if (rsp1_data !== expData[c]) begin nerr++; $display("FAIL len0_data c=%0d: got %h want %h", c, rsp1_data, expData[c]); end
            if (c == 3) begin req1_valid = 1'b1; req1_syms = 16'hFFFF; req1_len = 4'd0; end
            if (expSt[c][4]) begin @(posedge Clk); #1; req1_valid = 1'b0; end
        end
    endtask

    task automatic test_len_clamp();
        logic [5:0]  expSt;
        logic [15:0] expData;
        do_reset();
        req0_valid = 1'b1; req0_syms = 16'hFFFF; req0_len = 4'd15;
        for (int c = 0; c < 12; c++) begin
            if (c == 0) #1; else @(negedge Clk);
            if (c == 0)                expSt = 6'b100000;
            else if (c <= 8)           expSt = 6'b000011;
            else if (c == 10)          expSt = 6'b001000;
            else                       expSt = 6'b000000;
            expData = (c >= 10) ? 16'hFFFF : 16'h0000;
            nvec++;
            if (st !== expSt) begin nerr++; $display("FAIL clamp_status c=%0d: got %b want %b", c, st, expSt); end
            nvec++;
            if (rsp0_data !== expData) begin nerr++; $display("FAIL clamp_data c=%0d: got %h want %h", c, rsp0_data, expData); end
            if (c == 0) begin @(posedge Clk); #1; req0_valid = 1'b0; end
        end
    endtask

    task automatic test_reset_mid_drive();
        logic [5:0] expSt [4] = '{6'b100000, 6'b000011, 6'b000001, 6'b000010};
        logic [5:0] expB  [5] = '{6'b000001, 6'b000010, 6'b000000, 6'b000100, 6'b000000};
        do_reset();
        req0_valid = 1'b1; req0_syms = 16'h0BE7; req0_len = 4'd6;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) #1; else @(negedge Clk);
            nvec++;
            if (st !== expSt[c]) begin nerr++; $display("FAIL abort_drive c=%0d: got %b want %b", c, st, expSt[c]); end
            if (c == 0) begin @(posedge Clk); #1; req0_valid = 1'b0; end
        end
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            nvec++;
            if ({st, rsp0_data, rsp1_data} !== 38'd0) begin
                nerr++; $display("FAIL abort_quiet c=%0d: got %b %h %h want all zero", c, st, rsp0_data, rsp1_data);
            end
            @(negedge Clk);
        end
        req0_valid = 1'b1; req0_syms = 16'h0001; req0_len = 4'd1;
        req1_valid = 1'b1; req1_syms = 16'h0009; req1_len = 4'd2;
        #1;
        nvec++;
        if (st !== 6'b100000) begin nerr++; $display("FAIL abort_ptr_cleared: got %b want %b", st, 6'b100000); end
        req0_valid = 1'b0;
        #1;
        nvec++;
        if (st !== 6'b010000) begin nerr++; $display("FAIL abort_req1_grant: got %b want %b", st, 6'b010000); end
        @(posedge Clk); #1; req1_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            nvec++;
            if (st !== expB[c]) begin nerr++; $display("FAIL abort_req1_status c=%0d: got %b want %b", c, st, expB[c]); end
        end
        nvec++;
        if (rsp1_data !== 16'h0009) begin nerr++; $display("FAIL abort_req1_data: got %h want %h", rsp1_data, 16'h0009); end
    endtask

    task automatic test_lat3();
        logic [5:0]  expSt [8]   = '{6'b100000, 6'b000010, 6'b000001, 6'b000000,
                                     6'b000000, 6'b000000, 6'b001000, 6'b000000};
        logic [15:0] expData [8] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0006, 16'h0006};
        do_reset();
        b_req0_valid = 1'b1; b_req0_syms = 16'h0006; b_req0_len = 4'd2;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) #1; else @(negedge Clk);
            nvec++;
            if (b_st !== expSt[c]) begin nerr++; $display("FAIL lat3_status c=%0d: got %b want %b", c, b_st, expSt[c]); end
            nvec++;
            if (b_rsp0_data !== expData[c]) begin nerr++; $display("FAIL lat3_data c=%0d: got %h want %h", c, b_rsp0_data, expData[c]); end
            if (c == 0) begin @(posedge Clk); #1; b_req0_valid = 1'b0; end
        end
    endtask

    initial begin
        Rst = 1'b1;
        req0_valid = 1'b0; req0_syms = '0; req0_len = '0;
        req1_valid = 1'b0; req1_syms = '0; req1_len = '0;
        b_req0_valid = 1'b0; b_req0_syms = '0; b_req0_len = '0;
        b_req1_valid = 1'b0; b_req1_syms = '0; b_req1_len = '0;
        test_reset();
        test_single_burst();
        test_simultaneous();
        test_back_to_back();
        test_len_zero();
        test_len_clamp();
        test_reset_mid_drive();
        test_lat3();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule
